// File: rtl/comparator_pkg.sv
// Shared helpers for the comparator bank: index/diff widths and event field layout.
// Event word is {chan, level}, with level in bit 0 and chan above it.
package comparator_pkg;

  function automatic int calc_chw(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // One extra bit so p - n can never wrap.
  function automatic int diff_width(input int width);
    return width + 1;
  endfunction

  localparam int EVT_LEVEL_LSB = 0;
  localparam int EVT_CHAN_LSB  = 1;

  function automatic int evt_width(input int chw);
    return chw + 1;
  endfunction

endpackage

// File: rtl/comparator_bank_if.sv
// Sample inputs, level vector and event channel of the comparator bank.
// The bank sits on the slave side; the front end / consumer side is master.
interface comparator_bank_if
  import comparator_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 10,
  parameter int CHW    = calc_chw(NUM_CH)
);
  logic                     sample_en;
  logic [NUM_CH*WIDTH-1:0]  p_voltage_real;
  logic [NUM_CH*WIDTH-1:0]  n_voltage_real;
  logic [WIDTH-1:0]         hyst;
  logic [NUM_CH-1:0]        out_digital;
  logic                     evt_valid;
  logic                     evt_ready;
  logic [CHW-1:0]           evt_chan;
  logic                     evt_level;
  logic                     evt_overrun;

  modport master (
    output sample_en, p_voltage_real, n_voltage_real, hyst, evt_ready,
    input  out_digital, evt_valid, evt_chan, evt_level, evt_overrun
  );

  modport slave (
    input  sample_en, p_voltage_real, n_voltage_real, hyst, evt_ready,
    output out_digital, evt_valid, evt_chan, evt_level, evt_overrun
  );
endinterface

// File: rtl/comparator_channel.sv
// One hysteresis comparator with a consecutive-sample debounce counter.
// toggle is combinational: high on the strobe whose clock edge flips out.
module comparator_channel
  import comparator_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] hyst,
  output logic             out,
  output logic             toggle
);
  localparam int DW   = diff_width(WIDTH);
  localparam int CNTW = $clog2(DEBOUNCE + 1);

  logic signed [DW-1:0] w_diff;
  logic signed [DW-1:0] w_hyst_pos;
  logic signed [DW-1:0] w_hyst_neg;
  logic                 w_want;
  logic                 w_last;
  logic                 r_out;
  logic [CNTW-1:0]      r_cnt;

  assign w_diff     = $signed({p[WIDTH-1], p}) - $signed({n[WIDTH-1], n});
  assign w_hyst_pos = $signed({1'b0, hyst});
  assign w_hyst_neg = -w_hyst_pos;

  // Threshold equality never flips the level in either direction.
  assign w_want = r_out ? !(w_diff < w_hyst_neg) : (w_diff > w_hyst_pos);
  assign w_last = (r_cnt == CNTW'(DEBOUNCE - 1));
  assign toggle = sample_en && (w_want != r_out) && w_last;
  assign out    = r_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out <= 1'b0;
      r_cnt <= '0;
    end else if (sample_en) begin
      if (w_want == r_out) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_out <= ~r_out;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: rtl/comparator_bank.sv
// NUM_CH debounced hysteresis comparators; level changes become round-robin events.
// Event word is held while evt_valid && !evt_ready; reloads on acceptance.
module comparator_bank
  import comparator_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 10,
  parameter int DEBOUNCE = 3,
  parameter int CHW      = calc_chw(NUM_CH)
) (
  input  logic         clk,
  input  logic         reset,
  comparator_bank_if.slave bus
);
  localparam int EW = evt_width(CHW);

  logic [NUM_CH-1:0] w_out;
  logic [NUM_CH-1:0] w_toggle;
  logic [NUM_CH-1:0] w_consume;
  logic [NUM_CH-1:0] w_over_hit;
  logic [NUM_CH-1:0] r_pend;
  logic [CHW-1:0]    r_rr_ptr;
  logic [CHW-1:0]    w_sel;
  logic [CHW-1:0]    w_rr_next;
  logic              w_found;
  logic              w_load;
  logic              r_evt_valid;
  logic [EW-1:0]     r_evt;
  logic              r_overrun;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    comparator_channel #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sample_en (bus.sample_en),
      .p         (bus.p_voltage_real[g*WIDTH +: WIDTH]),
      .n         (bus.n_voltage_real[g*WIDTH +: WIDTH]),
      .hyst      (bus.hyst),
      .out       (w_out[g]),
      .toggle    (w_toggle[g])
    );
  end

  // Scan from the far end back towards rr_ptr so the nearest pending index wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (r_pend[idx]) begin
        w_found = 1'b1;
        w_sel   = CHW'(idx);
      end
    end
  end

  assign w_rr_next = (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + CHW'(1);
  assign w_load    = !r_evt_valid || bus.evt_ready;
  assign w_consume = (w_load && w_found) ? (NUM_CH'(1) << w_sel) : '0;

  always_comb begin
    w_over_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_over_hit[i] = w_toggle[i] &&
                      (r_pend[i] ||
                       (r_evt_valid && !bus.evt_ready &&
                        r_evt[EVT_CHAN_LSB +: CHW] == CHW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend      <= '0;
      r_rr_ptr    <= '0;
      r_evt_valid <= 1'b0;
      r_evt       <= '0;
      r_overrun   <= 1'b0;
    end else begin
      // A new toggle on a channel being consumed this cycle keeps its pending bit.
      r_pend <= (r_pend & ~w_consume) | w_toggle;
      if (|w_over_hit) r_overrun <= 1'b1;
      if (w_load) begin
        if (w_found) begin
          r_evt_valid                <= 1'b1;
          r_evt[EVT_CHAN_LSB +: CHW] <= w_sel;
          r_evt[EVT_LEVEL_LSB]       <= w_out[w_sel];
          r_rr_ptr                   <= w_rr_next;
        end else begin
          r_evt_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.out_digital = w_out;
  assign bus.evt_valid   = r_evt_valid;
  assign bus.evt_chan    = r_evt[EVT_CHAN_LSB +: CHW];
  assign bus.evt_level   = r_evt[EVT_LEVEL_LSB];
  assign bus.evt_overrun = r_overrun;
endmodule

// File: tb/tb_comparator_bank.sv
// Self-checking bench for comparator_bank: vector table plus handwritten
// backpressure/overrun/reset sequences, with an event scoreboard.
module tb_comparator_bank;
  import comparator_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int WIDTH    = 10;
  localparam int DEBOUNCE = 3;
  localparam int CHW      = calc_chw(NUM_CH);

  typedef struct {
    int         ch;
    int         p;
    int         n;
    int         h;
    bit         se;
    logic [3:0] exp_out;
    bit         push;
    int         pch;
    bit         plev;
  } vec_t;

  typedef struct packed {
    logic [CHW-1:0] chan;
    logic           level;
  } evt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  evt_t exp_q[$];
  evt_t mon_e;

  always #5 clk = ~clk;

  comparator_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CHW(CHW)) bus ();

  comparator_bank #(
    .NUM_CH   (NUM_CH),
    .WIDTH    (WIDTH),
    .DEBOUNCE (DEBOUNCE),
    .CHW      (CHW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.p_voltage_real = '0;
    bus.n_voltage_real = '0;
  endtask

  task automatic set_ch(input int ch, input int p, input int n);
    bus.p_voltage_real[ch*WIDTH +: WIDTH] = WIDTH'(p);
    bus.n_voltage_real[ch*WIDTH +: WIDTH] = WIDTH'(n);
  endtask

  task automatic strobe(input int reps);
    bus.sample_en = 1'b1;
    repeat (reps) tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic push_evt(input int ch, input bit lvl);
    exp_q.push_back('{chan: CHW'(ch), level: lvl});
  endtask

  task automatic add(input int ch, input int p, input int n, input int h, input bit se,
                     input logic [3:0] exp_out, input bit push, input int pch, input bit plev);
    tbl.push_back('{ch: ch, p: p, n: n, h: h, se: se, exp_out: exp_out,
                    push: push, pch: pch, plev: plev});
  endtask

  // Each accepted handshake is compared against the oldest expected event.
  always @(negedge clk) begin
    if (reset && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL evt_unexpected: got chan %0d level %0d, expected no event",
                 bus.evt_chan, bus.evt_level);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_chan", int'(bus.evt_chan), int'(mon_e.chan));
        check("evt_level", int'(bus.evt_level), int'(mon_e.level));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold with every channel driven well above threshold.
    bus.sample_en = 1'b1;
    bus.evt_ready = 1'b1;
    bus.hyst      = WIDTH'(5);
    clear_in();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 100, 0);
    repeat (5) tick();
    check("rst_out", int'(bus.out_digital), 0);
    check("rst_valid", int'(bus.evt_valid), 0);
    check("rst_chan", int'(bus.evt_chan), 0);
    check("rst_level", int'(bus.evt_level), 0);
    check("rst_overrun", int'(bus.evt_overrun), 0);

    reset = 1'b1;
    tick();
    check("deb_s1", int'(bus.out_digital), 0);
    tick();
    check("deb_s2", int'(bus.out_digital), 0);
    tick();
    check("deb_s3", int'(bus.out_digital), 4'b1111);
    for (int c = 0; c < NUM_CH; c++) push_evt(c, 1'b1);
    bus.sample_en = 1'b0;
    repeat (8) tick();
    check("drain_reset", exp_q.size(), 0);

    // Hysteresis on ch0 (hyst=5), starting from level 1.
    for (int i = 0; i < 3; i++) add(0, -5, 0, 5, 1, 4'b1111, 0, 0, 0);
    add(0, -6, 0, 5, 1, 4'b1111, 0, 0, 0);
    add(0, -6, 0, 5, 1, 4'b1111, 0, 0, 0);
    add(0, -6, 0, 5, 1, 4'b1110, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 5, 0, 5, 1, 4'b1110, 0, 0, 0);
    add(0, 6, 0, 5, 1, 4'b1110, 0, 0, 0);
    add(0, 6, 0, 5, 1, 4'b1110, 0, 0, 0);
    add(0, 6, 0, 5, 1, 4'b1111, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, -5, 0, 5, 1, 4'b1111, 0, 0, 0);
    add(0, -6, 0, 5, 1, 4'b1111, 0, 0, 0);
    add(0, -6, 0, 5, 1, 4'b1111, 0, 0, 0);
    add(0, -6, 0, 5, 1, 4'b1110, 1, 0, 0);
    // Debounce on ch1 (hyst=0): bring it low, then 20,20,0,20,20,20 with idle gaps.
    add(1, -20, 0, 0, 1, 4'b1110, 0, 0, 0);
    add(1, -20, 0, 0, 1, 4'b1110, 0, 0, 0);
    add(1, -20, 0, 0, 1, 4'b1100, 1, 1, 0);
    add(1, 20, 0, 0, 1, 4'b1100, 0, 0, 0);
    add(1, 20, 0, 0, 1, 4'b1100, 0, 0, 0);
    add(1, 20, 0, 0, 0, 4'b1100, 0, 0, 0);
    add(1, 0, 0, 0, 1, 4'b1100, 0, 0, 0);
    add(1, 20, 0, 0, 1, 4'b1100, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'b1100, 0, 0, 0);
    add(1, 20, 0, 0, 1, 4'b1100, 0, 0, 0);
    add(1, 20, 0, 0, 1, 4'b1110, 1, 1, 1);
    // Full-scale inputs on ch3: the difference must not wrap.
    for (int i = 0; i < 3; i++) add(3, 511, -512, 0, 1, 4'b1110, 0, 0, 0);
    add(3, -512, 511, 0, 1, 4'b1110, 0, 0, 0);
    add(3, -512, 511, 0, 1, 4'b1110, 0, 0, 0);
    add(3, -512, 511, 0, 1, 4'b0110, 1, 3, 0);
    add(3, 511, -512, 0, 1, 4'b0110, 0, 0, 0);
    add(3, 511, -512, 0, 1, 4'b0110, 0, 0, 0);
    add(3, 511, -512, 0, 1, 4'b1110, 1, 3, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      clear_in();
      set_ch(tbl[i].ch, tbl[i].p, tbl[i].n);
      bus.hyst      = WIDTH'(tbl[i].h);
      bus.sample_en = tbl[i].se;
      tick();
      check($sformatf("vec%0d_out", i), int'(bus.out_digital), int'(tbl[i].exp_out));
      if (tbl[i].push) push_evt(tbl[i].pch, tbl[i].plev);
    end
    bus.sample_en = 1'b0;
    clear_in();
    repeat (6) tick();
    check("drain_table", exp_q.size(), 0);

    // Backpressure and round robin: ch2 first, then ch0 and ch3 together.
    bus.evt_ready = 1'b0;
    bus.hyst      = '0;
    set_ch(2, -20, 0);
    strobe(3);
    check("bp_out1", int'(bus.out_digital), 4'b1010);
    push_evt(2, 1'b0);
    clear_in();
    set_ch(0, 20, 0);
    set_ch(3, -20, 0);
    strobe(3);
    check("bp_out2", int'(bus.out_digital), 4'b0011);
    push_evt(3, 1'b0);
    push_evt(0, 1'b1);
    clear_in();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", int'(bus.evt_valid), 1);
      check("bp_hold_chan", int'(bus.evt_chan), 2);
      check("bp_hold_level", int'(bus.evt_level), 0);
    end
    bus.evt_ready = 1'b1;
    tick();
    check("rr_b2b_valid1", int'(bus.evt_valid), 1);
    check("rr_b2b_chan1", int'(bus.evt_chan), 3);
    tick();
    check("rr_b2b_valid2", int'(bus.evt_valid), 1);
    check("rr_b2b_chan2", int'(bus.evt_chan), 0);
    tick();
    check("rr_b2b_idle", int'(bus.evt_valid), 0);
    check("drain_rr", exp_q.size(), 0);
    check("rr_overrun", int'(bus.evt_overrun), 0);

    // Overrun: ch0 occupies the event slot while ch1 goes 0 -> 1 -> 0.
    set_ch(1, -20, 0);
    strobe(3);
    push_evt(1, 1'b0);
    clear_in();
    repeat (4) tick();
    check("ov_pre_out", int'(bus.out_digital), 4'b0001);
    bus.evt_ready = 1'b0;
    set_ch(0, -20, 0);
    strobe(3);
    push_evt(0, 1'b0);
    clear_in();
    set_ch(1, 20, 0);
    strobe(3);
    check("ov_first_out", int'(bus.out_digital), 4'b0010);
    check("ov_first_flag", int'(bus.evt_overrun), 0);
    clear_in();
    set_ch(1, -20, 0);
    strobe(3);
    check("ov_second_out", int'(bus.out_digital), 4'b0000);
    check("ov_second_flag", int'(bus.evt_overrun), 1);
    push_evt(1, 1'b0);
    clear_in();
    repeat (3) tick();
    check("ov_sticky", int'(bus.evt_overrun), 1);
    bus.evt_ready = 1'b1;
    repeat (4) tick();
    check("drain_ov", exp_q.size(), 0);
    check("ov_after_drain", int'(bus.evt_overrun), 1);
    check("ov_idle", int'(bus.evt_valid), 0);

    // Reset while an event is presented drops it and clears the overrun flag.
    bus.evt_ready = 1'b0;
    set_ch(0, 20, 0);
    strobe(3);
    tick();
    check("mid_valid", int'(bus.evt_valid), 1);
    reset = 1'b0;
    clear_in();
    tick();
    check("mid_rst_valid", int'(bus.evt_valid), 0);
    check("mid_rst_overrun", int'(bus.evt_overrun), 0);
    check("mid_rst_out", int'(bus.out_digital), 0);
    check("mid_rst_chan", int'(bus.evt_chan), 0);
    reset = 1'b1;
    bus.evt_ready = 1'b1;
    repeat (4) tick();
    check("post_rst_valid", int'(bus.evt_valid), 0);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/comparator_bank.md
Name: comparator_bank

Overview:
- Parametrised successor to the single-channel comparator.
- Compares NUM_CH fixed-point differential input pairs, with programmable hysteresis and a per-channel sample-count debounce.
- Drives a level vector and reports every debounced level change as an event over a valid/ready channel, one event per handshake, arbitrated round-robin.
- Sits between the analog-to-fixed-point front end and digital control logic; replaces banks of individually instanced comparators.

Parameters:
- NUM_CH, 4, number of comparator channels (1..32).
- WIDTH, 10, bit width of each signed two's-complement input sample.
- DEBOUNCE, 3, consecutive qualifying samples needed to flip a channel output (>=1).
- CHW, $clog2(NUM_CH) (min 1), derived width of the channel index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- sample_en  in  1  sample strobe; channels evaluate only on cycles where it is high.
- p_voltage_real  in  NUM_CH*WIDTH  positive inputs; channel i is bits [i*WIDTH +: WIDTH], signed.
- n_voltage_real  in  NUM_CH*WIDTH  negative inputs, same packing.
- hyst  in  WIDTH  unsigned hysteresis magnitude, applied to all channels.
- out_digital  out  NUM_CH  debounced comparator levels.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_chan  out  CHW  channel index of the presented event.
- evt_level  out  1  new level of that channel.
- evt_overrun  out  1  sticky flag: a channel toggled while its previous event was still unreported.

Behaviour:
- Reset (reset==0 at a clk edge): out_digital=0, all debounce counters=0, pending=0, evt_valid=0, evt_chan=0, evt_level=0, evt_overrun=0, round-robin pointer=0. Reset mid-event drops all pending and presented events.
- Difference: diff_i = p_i - n_i, computed signed in WIDTH+1 bits (no overflow). hyst is zero-extended to WIDTH+1 bits.
- Raw decision, evaluated only when sample_en=1:
  - out_i=0: want_i=1 iff diff_i > +hyst, else 0.
  - out_i=1: want_i=0 iff diff_i < -hyst, else 1.
  - Equality with ±hyst never flips. hyst=0 gives a plain strict comparator.
- Debounce counter cnt_i, width $clog2(DEBOUNCE+1), only when sample_en=1:
  - want_i == out_i: cnt_i <= 0.
  - Otherwise cnt_i <= cnt_i+1. When cnt_i+1 == DEBOUNCE, out_i toggles and cnt_i <= 0.
  - sample_en=0: all counters and outputs hold.
- Latency, DEBOUNCE=1: sample at edge t -> out_digital changes after edge t -> evt_valid high after edge t+1. In general, DEBOUNCE consecutive qualifying strobes are needed.
- Pending: toggle of channel i sets pending_i. If pending_i is already set, or channel i is currently presented and not yet accepted, evt_overrun <= 1. evt_overrun is cleared only by reset.
- Event register:
  - Loads when evt_valid=0, or when evt_valid&&evt_ready (same-cycle reload allowed, giving back-to-back events).
  - Selects the lowest pending index at or after rr_ptr, wrapping modulo NUM_CH.
  - Loads evt_chan, sets evt_level=out_digital[chan] as currently registered, clears that pending bit, rr_ptr <= chan+1 (wraps to 0).
  - No pending bits -> evt_valid <= 0.
- While evt_valid && !evt_ready, evt_chan and evt_level are held stable.
- Simultaneous events: a toggle of channel i in the same cycle its pending bit is consumed leaves pending_i set (set wins).
- evt_ready while evt_valid=0 is ignored.

Decomposition:
- Package comparator_pkg holds:
  - the CHW derivation function;
  - a signed diff width macro/constant (WIDTH+1);
  - the event field layout {chan, level}, for reuse by a future event FIFO.
- Sub-module comparator_channel: hysteresis compare plus debounce counter for one channel.
  - Ports: clk, reset, sample_en, p, n, hyst, out, toggle.
  - Instantiated NUM_CH times by generate.
- Pending vector, round-robin arbiter and event register live in the top.

Test Plan:
- Reset hold: reset=0 with hyst=5, p=100, n=0 on all channels -> every output 0, no events. Release reset; NUM_CH=4, DEBOUNCE=3, three strobes -> out_digital=4'b1111, then events chan 0,1,2,3 in order, level 1, with evt_ready tied high.
- Hysteresis: ch0 hyst=5; p-n = 5 -> stays 0; p-n = 6 for 3 strobes -> out=1; p-n = -5 -> stays 1; p-n = -6 for 3 strobes -> out=0.
- Debounce: ch1 with p-n = 20, 20, 0, 20, 20, 20 (hyst=0) -> the counter resets on the 0 sample; out flips only after the sixth strobe. sample_en low between strobes leaves cnt unchanged.
- Backpressure and round robin: toggle ch2, then ch0 and ch3 together, with evt_ready=0 for 10 cycles -> evt_chan=2 held stable. Release ready -> events 2, 3, 0 on consecutive cycles.
- Overrun: evt_ready=0; ch1 toggles 1 then 0 -> evt_overrun=1 and stays set. Then the single ch1 event reports level 0; reset clears evt_overrun.
- Width extremes: WIDTH=10, p=+511, n=-512, hyst=0 -> diff=+1023 with no wrap, out=1. p=-512, n=+511 -> out returns to 0.
